// File: rtl/ieee754_pkg.sv
// rtl/ieee754_pkg.sv - shared constants and FSM encoding for the IEEE-754 single-precision cores
package ieee754_pkg;

    localparam int BIAS    = 127;
    localparam int EXP_INF = 255;
    localparam int MANT_W  = 23;
    localparam int GUARD_W = 8;

    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_NORM   = 3'd1;
    localparam logic [2:0] ST_DENORM = 3'd2;
    localparam logic [2:0] ST_ROUND  = 3'd3;
    localparam logic [2:0] ST_PACK   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

endpackage

// File: rtl/ieee754_round_ne.sv
// rtl/ieee754_round_ne.sv - combinational round-to-nearest-even on an unpacked 1.23+8 guard fraction
module ieee754_round_ne
    import ieee754_pkg::*;
(
    input  logic [31:0] frac,
    output logic [31:0] rounded,
    output logic        carry
);

    localparam int KEEP_W = MANT_W + 1;

    logic              guard_bit;
    logic              sticky_bit;
    logic              lsb_bit;
    logic              inc;
    logic [KEEP_W:0]   sum;

    assign guard_bit  = frac[GUARD_W-1];
    assign sticky_bit = |frac[GUARD_W-2:0];
    assign lsb_bit    = frac[GUARD_W];
    assign inc        = guard_bit & (sticky_bit | lsb_bit);

    assign sum   = {1'b0, frac[31:GUARD_W]} + {{KEEP_W{1'b0}}, inc};
    assign carry = sum[KEEP_W];

    // A carry out of the hidden bit renormalizes to 1.0; the caller bumps the exponent.
    assign rounded = carry ? 32'h8000_0000 : {sum[KEEP_W-1:0], {GUARD_W{1'b0}}};

endmodule

// File: rtl/ieee754_compose_seq.sv
// rtl/ieee754_compose_seq.sv - iterative unpacked-to-IEEE-754 composer; IEEE754_DENORM_EN enables subnormal output
module ieee754_compose_seq
    import ieee754_pkg::*;
#(
    parameter int NORM_MAX   = 31,
    parameter int DENORM_MAX = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] fraction,
    input  logic [31:0] exponent,
    input  logic        sign,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] float,
    output logic        overflow,
    output logic        underflow
);

    localparam int ITER_MAX = (NORM_MAX > DENORM_MAX) ? NORM_MAX : DENORM_MAX;
    localparam int CNT_W    = $clog2(ITER_MAX + 1);

    localparam logic [CNT_W-1:0] NORM_LIM   = CNT_W'(NORM_MAX);
    localparam logic [CNT_W-1:0] DENORM_LIM = CNT_W'(DENORM_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [2:0]        state;
    logic [31:0]       frac;
    logic signed [31:0] exp;
    logic              sgn;
    logic              zero;
    logic [CNT_W-1:0]  cnt;

    logic [31:0]       rnd_frac;
    logic              rnd_carry;

    ieee754_round_ne u_round (
        .frac    (frac),
        .rounded (rnd_frac),
        .carry   (rnd_carry)
    );

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            frac      <= '0;
            exp       <= '0;
            sgn       <= 1'b0;
            zero      <= 1'b0;
            cnt       <= '0;
            float     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        frac  <= fraction;
                        exp   <= exponent;
                        sgn   <= sign;
                        zero  <= 1'b0;
                        cnt   <= '0;
                        state <= ST_NORM;
                    end
                end

                ST_NORM: begin
                    if (frac == 32'd0) begin
                        zero  <= 1'b1;
                        state <= ST_PACK;
                    end else if (frac[31] || cnt == NORM_LIM) begin
                        cnt <= '0;
`ifdef IEEE754_DENORM_EN
                        state <= (exp < 32'sd1) ? ST_DENORM : ST_ROUND;
`else
                        state <= ST_ROUND;
`endif
                    end else begin
                        frac <= {frac[30:0], 1'b0};
                        exp  <= exp - 32'sd1;
                        cnt  <= cnt + CNT_ONE;
                    end
                end

`ifdef IEEE754_DENORM_EN
                // Bits shifted out stay folded into bit 0 so rounding still sees them as sticky.
                ST_DENORM: begin
                    frac <= {1'b0, frac[31:2], frac[1] | frac[0]};
                    exp  <= exp + 32'sd1;
                    cnt  <= cnt + CNT_ONE;
                    if (exp == 32'sd0 || (cnt + CNT_ONE) == DENORM_LIM) begin
                        state <= ST_ROUND;
                    end
                end
`endif

                ST_ROUND: begin
                    frac <= rnd_frac;
                    if (rnd_carry) begin
                        exp <= exp + 32'sd1;
                    end
                    state <= ST_PACK;
                end

                ST_PACK: begin
                    if (zero) begin
                        float     <= {sgn, 31'd0};
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                    end else if (exp >= EXP_INF) begin
                        float     <= {sgn, POS_INF[30:0]};
                        overflow  <= 1'b1;
                        underflow <= 1'b0;
`ifndef IEEE754_DENORM_EN
                    end else if (exp <= 32'sd0) begin
                        float     <= {sgn, 31'd0};
                        overflow  <= 1'b0;
                        underflow <= 1'b1;
`endif
                    end else begin
                        // Without the hidden bit the value is subnormal and the exponent field is 0.
                        float     <= {sgn, (frac[31] ? exp[7:0] : 8'h00), frac[30:8]};
                        overflow  <= 1'b0;
                        underflow <= ~frac[31];
                    end
                    state <= ST_DONE;
                end

                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
